// File: rtl/chance_round_sequencer.sv
// chance_round_sequencer
//   Game controller for the chance-loop roller. Starts a game, lets the external roller
//   free-run, turns each debounced player stop press into one captured roll, and after ROUNDS
//   captures offers the wrapped sum of the rolls on a valid/ready result port.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-high reset
//   i_start      begins a game when sampled in IDLE
//   i_stop       raw asynchronous player button, active-high
//   i_roll_val   current roller count from the datapath
//   i_res_ready  result consumer ready
//   o_roll_en    roller increment enable
//   o_roll_clr   roller synchronous clear
//   o_round_idx  captures completed in the current game
//   o_busy       high whenever a game is in progress or its result is pending
//   o_res_valid  result valid
//   o_res_data   game sum, stable while o_res_valid is high
module chance_round_sequencer #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned ROUNDS  = 3,
  parameter int unsigned SUM_W   = 7,
  parameter int unsigned LOCKOUT = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic [CNT_W-1:0]             i_roll_val,
  input  logic                         i_res_ready,
  output logic                         o_roll_en,
  output logic                         o_roll_clr,
  output logic [$clog2(ROUNDS+1)-1:0]  o_round_idx,
  output logic                         o_busy,
  output logic                         o_res_valid,
  output logic [SUM_W-1:0]             o_res_data
);

  localparam int unsigned IDX_W = $clog2(ROUNDS + 1);
  localparam int unsigned LCK_W = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StSpin,
    StCapture,
    StDone
  } state_e;

  state_e             r_state;
  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic [LCK_W-1:0]   r_lockout;
  logic [SUM_W-1:0]   r_acc;
  logic [IDX_W-1:0]   r_round_idx;
  logic               r_roll_en;
  logic               r_roll_clr;
  logic               r_busy;
  logic               r_res_valid;
  logic [SUM_W-1:0]   r_res_data;

  logic               w_stop_evt;
  logic               w_evt_valid;
  logic [SUM_W-1:0]   w_roll_ext;
  logic [SUM_W-1:0]   w_acc_next;
  logic [IDX_W-1:0]   w_idx_next;
  logic               w_last;

  // Button synchronizer and rising-edge detector. The pipeline is held clear while idle so a
  // press that lands in IDLE (even one coincident with start) never turns into a capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (r_state == StIdle) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_stop;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_stop_evt  = r_s2 & ~r_s3;
  assign w_evt_valid = w_stop_evt && (r_lockout == '0);
  // Zero-extend (or truncate) the roll into the accumulator width; the sum wraps naturally.
  assign w_roll_ext  = SUM_W'(i_roll_val);
  assign w_acc_next  = r_acc + w_roll_ext;
  assign w_idx_next  = r_round_idx + IDX_W'(1);
  assign w_last      = (w_idx_next == IDX_W'(ROUNDS));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_roll_en   <= 1'b0;
      r_roll_clr  <= 1'b1;
      r_round_idx <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_acc       <= '0;
      r_lockout   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state     <= StSpin;
            r_roll_clr  <= 1'b0;
            r_roll_en   <= 1'b1;
            r_busy      <= 1'b1;
            r_acc       <= '0;
            r_round_idx <= '0;
            r_lockout   <= '0;
          end
        end
        StSpin: begin
          if (r_lockout != '0) begin
            r_lockout <= r_lockout - LCK_W'(1);
          end
          if (w_evt_valid) begin
            // Freeze the roller for the capture cycle.
            r_state   <= StCapture;
            r_roll_en <= 1'b0;
          end
        end
        StCapture: begin
          r_acc       <= w_acc_next;
          r_round_idx <= w_idx_next;
          r_lockout   <= LCK_W'(LOCKOUT);
          if (w_last) begin
            r_state     <= StDone;
            r_res_data  <= w_acc_next;
            r_res_valid <= 1'b1;
          end else begin
            // Roller resumes from where it stopped, no clear between rounds.
            r_state   <= StSpin;
            r_roll_en <= 1'b1;
          end
        end
        StDone: begin
          if (i_res_ready) begin
            r_state     <= StIdle;
            r_res_valid <= 1'b0;
            r_roll_clr  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_roll_en   = r_roll_en;
  assign o_roll_clr  = r_roll_clr;
  assign o_round_idx = r_round_idx;
  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;

endmodule

// File: tb/tb_chance_round_sequencer.sv
// Testbench for chance_round_sequencer. Runs a default instance (SUM_W=7) and a SUM_W=4
// instance side by side on the same stimulus; the bench owns the 4-bit roller.
module tb_chance_round_sequencer;

  localparam int unsigned LOCKOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       res_ready;
  logic [3:0] roller = '0;

  logic       roll_en, roll_clr, busy, res_valid;
  logic [1:0] round_idx;
  logic [6:0] res_data;

  logic       roll_en_n, roll_clr_n, busy_n, res_valid_n;
  logic [1:0] round_idx_n;
  logic [3:0] res_data_n;

  int total = 0;
  int bad   = 0;
  int exp_idx;

  typedef struct {
    logic [3:0] r0;
    logic [3:0] r1;
    logic [3:0] r2;
    int         sum7;
    int         sum4;
    bit         hold;
    bit         extra;
    bit         stall;
  } vec_t;

  chance_round_sequencer #(
    .CNT_W  (4),
    .ROUNDS (3),
    .SUM_W  (7),
    .LOCKOUT(LOCKOUT)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_stop     (stop),
    .i_roll_val (roller),
    .i_res_ready(res_ready),
    .o_roll_en  (roll_en),
    .o_roll_clr (roll_clr),
    .o_round_idx(round_idx),
    .o_busy     (busy),
    .o_res_valid(res_valid),
    .o_res_data (res_data)
  );

  chance_round_sequencer #(
    .CNT_W  (4),
    .ROUNDS (3),
    .SUM_W  (4),
    .LOCKOUT(LOCKOUT)
  ) u_dut_narrow (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_stop     (stop),
    .i_roll_val (roller),
    .i_res_ready(res_ready),
    .o_roll_en  (roll_en_n),
    .o_roll_clr (roll_clr_n),
    .o_round_idx(round_idx_n),
    .o_busy     (busy_n),
    .o_res_valid(res_valid_n),
    .o_res_data (res_data_n)
  );

  always #5 clk = ~clk;

  // Roller datapath: +1 per enabled cycle, synchronous clear.
  always @(posedge clk) begin
    if (roll_clr) roller <= '0;
    else if (roll_en) roller <= roller + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // A press raised while the roller shows v is acted on three roller steps later, so raise it
  // at target-3 and the capture cycle must show target.
  task automatic do_capture(input logic [3:0] target, input bit hold);
    logic [3:0] pre;
    bit         found;
    pre   = target - 4'd3;
    found = 1'b0;
    repeat (LOCKOUT + 4) tick();
    for (int k = 0; k < 64; k++) begin
      if (roll_en && roller == pre) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("capture_wait", found, 1);
    if (!found) return;
    stop = 1'b1;
    tick();
    if (!hold) stop = 1'b0;
    tick();
    tick();
    check("cap_roll_en", roll_en, 0);
    check("cap_roll_val", roller, target);
    check("cap_idx_before", round_idx, exp_idx);
    tick();
    exp_idx++;
    check("cap_idx_after", round_idx, exp_idx);
    if (hold) begin
      repeat (16) tick();
      check("hold_one_capture", round_idx, exp_idx);
      stop = 1'b0;
    end
  endtask

  task automatic play_game(input vec_t v);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_idx = 0;
    check("start_busy", busy, 1);
    check("start_roll_en", roll_en, 1);
    check("start_roll_clr", roll_clr, 0);
    check("start_idx", round_idx, 0);
    do_capture(v.r0, v.hold);
    do_capture(v.r1, 1'b0);
    if (v.extra) begin
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (10) tick();
      check("lockout_press_ignored", round_idx, exp_idx);
      check("lockout_still_spin", roll_en, 1);
    end
    do_capture(v.r2, 1'b0);
    check("done_valid", res_valid, 1);
    check("done_data", res_data, v.sum7);
    check("done_data_narrow", res_data_n, v.sum4);
    check("done_idx", round_idx, 3);
    check("done_busy", busy, 1);
    check("done_roll_en", roll_en, 0);
    check("done_roll_clr", roll_clr, 0);
    if (v.stall) begin
      for (int c = 0; c < 10; c++) begin
        start = (c == 3);
        tick();
        check("stall_valid", res_valid, 1);
        check("stall_data", res_data, v.sum7);
        check("stall_busy", busy, 1);
      end
      start = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hs_valid", res_valid, 0);
    check("hs_busy", busy, 0);
    check("hs_roll_clr", roll_clr, 1);
    check("hs_data_held", res_data, v.sum7);
    tick();
    check("idle_stays", busy, 0);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t rv;
    int   s;

    vecs[0] = '{r0: 4'd5,  r1: 4'd3,  r2: 4'd9,  sum7: 17, sum4: 1,  hold: 0, extra: 0, stall: 1};
    vecs[1] = '{r0: 4'd15, r1: 4'd15, r2: 4'd15, sum7: 45, sum4: 13, hold: 1, extra: 1, stall: 0};
    vecs[2] = '{r0: 4'd0,  r1: 4'd0,  r2: 4'd0,  sum7: 0,  sum4: 0,  hold: 0, extra: 0, stall: 0};
    vecs[3] = '{r0: 4'd7,  r1: 4'd12, r2: 4'd1,  sum7: 20, sum4: 4,  hold: 0, extra: 0, stall: 0};

    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    res_ready = 1'b0;
    exp_idx   = 0;
    tick();
    tick();
    check("rst_roll_en", roll_en, 0);
    check("rst_roll_clr", roll_clr, 1);
    check("rst_idx", round_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    reset = 1'b0;
    tick();

    // Stop presses while idle do nothing.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (5) tick();
    check("idle_stop_busy", busy, 0);
    check("idle_stop_idx", round_idx, 0);
    check("idle_stop_clr", roll_clr, 1);
    check("idle_stop_en", roll_en, 0);

    for (int i = 0; i < 4; i++) play_game(vecs[i]);

    // Start and stop together in IDLE: game starts, no capture.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    exp_idx = 0;
    check("coinc_busy", busy, 1);
    repeat (10) tick();
    check("coinc_no_capture", round_idx, 0);
    check("coinc_roll_en", roll_en, 1);

    // One capture, then an asynchronous reset between edges aborts the game.
    do_capture(4'd6, 1'b0);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("async_roll_en", roll_en, 0);
    check("async_roll_clr", roll_clr, 1);
    check("async_idx", round_idx, 0);
    check("async_busy", busy, 0);
    check("async_valid", res_valid, 0);
    check("async_data", res_data, 0);
    check("async_data_narrow", res_data_n, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);

    for (int g = 0; g < 20; g++) begin
      rv.r0 = 4'($urandom_range(15, 0));
      rv.r1 = 4'($urandom_range(15, 0));
      rv.r2 = 4'($urandom_range(15, 0));
      s = int'(rv.r0) + int'(rv.r1) + int'(rv.r2);
      rv.sum7  = s % 128;
      rv.sum4  = s % 16;
      rv.hold  = 1'b0;
      rv.extra = ($urandom_range(1, 0) == 1);
      rv.stall = ($urandom_range(3, 0) == 0);
      play_game(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
